// File: rtl/decontatore_base_10_pkg.sv
// -----------------------------------------------------------------------------
// decontatore_base_10_pkg
// Shared definitions for the base-10 counter family:
//   - BCD digit constants CIFRA_0 / CIFRA_9
//   - FSM state encoding stato_t (FERMO = idle, CONTA = counting)
//   - cifra_valida(): checks that a nibble is a legal BCD digit (0000-1001)
// -----------------------------------------------------------------------------
package decontatore_base_10_pkg;

   localparam logic [3:0] CIFRA_0 = 4'd0;
   localparam logic [3:0] CIFRA_9 = 4'd9;

   typedef enum logic {
      FERMO = 1'b0,
      CONTA = 1'b1
   } stato_t;

   function automatic logic cifra_valida(input logic [3:0] cifra);
      return (cifra <= CIFRA_9);
   endfunction

endpackage

// File: rtl/cifra_decrementatore_base_10.sv
// -----------------------------------------------------------------------------
// cifra_decrementatore_base_10
// Single-digit combinational BCD decrementer, one link of a borrow chain.
// Ports:
//   cifra     in  [3:0]  current BCD digit
//   bi        in         borrow in (decrement request for this digit)
//   cifra_dec out [3:0]  digit after applying bi
//   bu        out        borrow out: set when bi wraps 0 -> 9
// -----------------------------------------------------------------------------
module cifra_decrementatore_base_10
   import decontatore_base_10_pkg::*;
(
   input  logic [3:0] cifra,
   input  logic       bi,
   output logic [3:0] cifra_dec,
   output logic       bu
);

   always_comb begin
      cifra_dec = cifra;
      bu        = 1'b0;
      if (bi) begin
         if (cifra == CIFRA_0) begin
            cifra_dec = CIFRA_9;
            bu        = 1'b1;
         end else begin
            cifra_dec = cifra - 4'd1;
         end
      end
   end

endmodule

// File: rtl/decontatore_base_10.sv
// -----------------------------------------------------------------------------
// decontatore_base_10
// Multi-digit BCD down-counter (countdown timer). Loads a BCD value and
// decrements it on each enabled cycle; stops at zero with a one-cycle 'fine'
// pulse, or in wrap mode rolls 0 -> 99..9 and asserts 'eu' for cascading.
// Ports:
//   clock    in                 rising-edge clock
//   reset    in                 asynchronous active-high reset
//   carica   in                 load request (highest priority)
//   d        in  [4*N_CIFRE-1:0] BCD load value, MS digit in top nibble
//   ei       in                 decrement enable, honoured only in CONTA
//   ciclico  in                 1 = wrap mode, 0 = stop-at-zero mode
//   q        out [4*N_CIFRE-1:0] current BCD count (registered)
//   eu       out                borrow out (combinational)
//   attivo   out                high while counting (registered)
//   fine     out                countdown reached zero (registered pulse)
//   errore   out                load rejected, invalid BCD (registered pulse)
// -----------------------------------------------------------------------------
module decontatore_base_10
   import decontatore_base_10_pkg::*;
#(
   parameter int N_CIFRE = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   carica,
   input  logic [4*N_CIFRE-1:0]   d,
   input  logic                   ei,
   input  logic                   ciclico,
   output logic [4*N_CIFRE-1:0]   q,
   output logic                   eu,
   output logic                   attivo,
   output logic                   fine,
   output logic                   errore
);

   localparam int W = 4 * N_CIFRE;

   stato_t         stato, stato_next;
   logic [W-1:0]   q_next;
   logic [W-1:0]   q_dec;
   logic           fine_next;
   logic           errore_next;
   logic           d_valido;
   logic           q_zero;
   logic           q_dec_zero;
   logic [N_CIFRE:0] prestito;

   // The chain is fed with the real tick condition, so the final borrow is
   // exactly "a decrement is happening from all zeros"; eu then only needs
   // the wrap-mode qualifier.
   assign prestito[0] = attivo & ei & ~carica;

   for (genvar k = 0; k < N_CIFRE; k++) begin : g_cifre
      cifra_decrementatore_base_10 u_cifra (
         .cifra     (q[4*k +: 4]),
         .bi        (prestito[k]),
         .cifra_dec (q_dec[4*k +: 4]),
         .bu        (prestito[k+1])
      );
   end

   assign eu         = prestito[N_CIFRE] & ciclico;
   assign q_zero     = (q == '0);
   assign q_dec_zero = (q_dec == '0);

   always_comb begin
      d_valido = 1'b1;
      for (int k = 0; k < N_CIFRE; k++) begin
         if (!cifra_valida(d[4*k +: 4])) begin
            d_valido = 1'b0;
         end
      end
   end

   always_comb begin
      stato_next  = stato;
      q_next      = q;
      fine_next   = 1'b0;
      errore_next = 1'b0;
      if (carica) begin
         if (!d_valido) begin
            errore_next = 1'b1;
         end else if (d == '0) begin
            q_next     = '0;
            stato_next = FERMO;
         end else begin
            q_next     = d;
            stato_next = CONTA;
         end
      end else if (stato == CONTA) begin
         if (q_zero && !ciclico) begin
            // zero left over from wrap mode after ciclico dropped
            stato_next = FERMO;
            fine_next  = 1'b1;
         end else if (ei) begin
            q_next = q_dec;
            if (!ciclico && !q_zero && q_dec_zero) begin
               stato_next = FERMO;
               fine_next  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stato  <= FERMO;
         q      <= '0;
         attivo <= 1'b0;
         fine   <= 1'b0;
         errore <= 1'b0;
      end else begin
         stato  <= stato_next;
         q      <= q_next;
         attivo <= (stato_next == CONTA);
         fine   <= fine_next;
         errore <= errore_next;
      end
   end

endmodule

// File: doc/decontatore_base_10.md
# decontatore_base_10

Multi-digit BCD down-counter (countdown timer) built from a chain of base-10 decrementer elements with borrow propagation. It loads a BCD value and decrements it on each enabled cycle. It either stops at zero and signals completion, or wraps 0 → 99…9 and emits a borrow so that further counters can be cascaded. It is the decrementing counterpart of the base-10 incrementer counter elements: 8-4-2-1 digit encoding, enable-in / borrow-out chaining.

## Interface
- `N_CIFRE`, default 4: number of BCD digits; the legal range is 1–8.
- `clock` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `carica` in 1: load request for `d`.
- `d` in 4·N_CIFRE: BCD load value, with the most significant digit in the top nibble.
- `ei` in 1: decrement enable (tick); honoured only while counting.
- `ciclico` in 1: 1 selects wrap-around mode, 0 selects stop-at-zero mode. It is sampled every cycle.
- `q` out 4·N_CIFRE: current BCD count, registered.
- `eu` out 1: borrow out; combinational.
- `attivo` out 1: high while the FSM is in CONTA; registered.
- `fine` out 1: one-cycle pulse when a countdown reaches zero; registered.
- `errore` out 1: one-cycle pulse when a load is rejected; registered.

## Operation
- **Digit encoding:** 0000–1001 only. The decrement rule per digit is d−1 with no borrow, except 0 → 9 with borrow. Digit k receives the borrow of digit k−1, and digit 0 receives `ei`.
- **FSM states:** FERMO (idle) and CONTA (counting).
- **Reset values:** q=0, state=FERMO, attivo=0, fine=0, errore=0. As a consequence, eu=0.
- **Load with `carica`=1 at an edge (highest priority):**
  - If any nibble of `d` is greater than 1001: reject the load. q and state are unchanged and errore=1 for one cycle.
  - Else, if d=0: q←0, state←FERMO, and fine is not pulsed.
  - Else: q←d and state←CONTA.
- **CONTA, `carica`=0, `ei`=1:** q←q−1 (BCD).
  - Stop mode (`ciclico`=0), q=1 before the edge: q becomes 0, state←FERMO and fine=1 for one cycle.
  - Wrap mode (`ciclico`=1), q=0: q←all nines and the state stays CONTA.
  - A zero count in CONTA arises only in wrap mode, or after `ciclico` falls; see the next rule.
- **CONTA with q=0 and `ciclico`=0:** at the next edge state←FERMO and fine=1, whatever the value of `ei`.
- **CONTA, `ei`=0:** hold.
- **FERMO:** `ei` is ignored and q holds.
- **`eu` function:** eu = attivo & ei & ciclico & (q==0) & ~carica. It is high for exactly the cycle in which the wrap occurs at the following edge.
- **Overlapping outputs:** fine and errore never assert in the same cycle.

## Timing
- **Load latency:** q and attivo update one edge after `carica` is sampled.
- **Decrement latency:** 1 cycle per tick.
- **Countdown length:** loading value V in stop mode with `ei` held at 1 gives fine high in cycle V after the load edge. Here cycle 1 is the cycle following the first decrement edge.
- **`eu` path:** purely combinational from q, attivo, ei, ciclico and carica. There is no registered delay, so downstream cascades see it in the same cycle.
- **Asynchronous reset:** asserting `reset` at any point, including mid-count, forces the reset values without waiting for a clock edge. Deassertion takes effect at the first edge after release.
- **Simultaneous load and tick:** `carica` and `ei` together means the load wins and no decrement happens that cycle.
- **`ciclico` changes:** a change takes effect at the next edge evaluation.

## Structure
- **Shared package:** the BCD digit constants (CIFRA_0, CIFRA_9), the FSM state encoding (FERMO, CONTA) and the BCD-validity helper belong in the shared counters package.
- **Sub-module:** `cifra_decrementatore_base_10`, a single-digit combinational decrementer with inputs digit[3:0] and bi, and outputs digit'[3:0] and bu. It is instantiated N_CIFRE times in a borrow chain.
- **Top level:** the top level contains only the q register, the FSM, the load/validity logic and the output registers.

## Test plan
All scenarios use N_CIFRE=4.
- **Reset mid-count:** load 0x0005, run 2 ticks, assert reset between edges → q=0000, attivo=0 immediately, with no fine pulse.
- **Stop-mode countdown:** load 0x0003 with ciclico=0 and ei held at 1 → q goes 0002, 0001, 0000; fine pulses once, on the edge where q reaches 0000; attivo falls on that same edge.
- **Borrow across digits:** load 0x1000 with one tick → q=0999. A further tick gives q=0998.
- **Wrap mode:** load 0x0001 with ciclico=1 and two ticks → q=0000, then eu=1 during the following cycle, then q=9999 with attivo still 1 and no fine pulse.
- **Invalid load:** while counting at 0x0042, apply carica with d=0x00A1 → q stays 0042, errore pulses once, attivo stays 1.
- **Priority and hold:** with carica and ei both high and d=0x0500, the load wins → q=0500. Then with ei=0 for 3 cycles → q holds 0500. In FERMO, ei=1 → q unchanged.
